// File: rtl/bidir_pin_ctrl.sv
// Sequencer for a single bidirectional pin: grants writes (drive) and reads
// (sample) one at a time and always releases the bus for a turnaround gap.
//
// state  | meaning
// IDLE   | pin released, waiting for wr_req / rd_req
// DRIVE  | dir=1, captured write value on data_out for DRIVE_CYC cycles
// SAMPLE | pin released, data_in sampled at the end of the RD_LAT-th cycle
// TURN   | pin released for TURN cycles before the next grant
module bidir_pin_ctrl #(
  parameter int WIDTH     = 1,
  parameter int DRIVE_CYC = 2,
  parameter int RD_LAT    = 2,
  parameter int TURN      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ack,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             dir,
  output logic [WIDTH-1:0] data_out,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_TURN   = 2'd3
  } state_t;

  // Counters load count-1 on entry and leave the state when they reach zero.
  localparam logic [3:0] DRIVE_LD = 4'(DRIVE_CYC - 1);
  localparam logic [3:0] RD_LD    = 4'(RD_LAT - 1);
  localparam logic [3:0] TURN_LD  = 4'(TURN - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             prio_wr_q, prio_wr_d;
  logic             grant_wr, grant_rd;
  logic             phase_done;
  logic             sample_now;

  logic             dir_d;
  logic [WIDTH-1:0] data_out_d;
  logic             wr_ack_d;
  logic             rd_ack_d;
  logic             rd_valid_d;
  logic [WIDTH-1:0] rd_data_d;
  logic             busy_d;

  // State register plus output registers; outputs are the registered image
  // of next-state decode, so nothing combinational reaches a port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      prio_wr_q <= 1'b1;
      dir       <= 1'b0;
      data_out  <= '0;
      wr_ack    <= 1'b0;
      rd_ack    <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_wr_q <= prio_wr_d;
      dir       <= dir_d;
      data_out  <= data_out_d;
      wr_ack    <= wr_ack_d;
      rd_ack    <= rd_ack_d;
      rd_valid  <= rd_valid_d;
      rd_data   <= rd_data_d;
      busy      <= busy_d;
    end
  end

  assign phase_done = (cnt_q == 4'd0);
  assign grant_wr   = (state_q == ST_IDLE) && wr_req && (!rd_req || prio_wr_q);
  assign grant_rd   = (state_q == ST_IDLE) && rd_req && !grant_wr;
  assign sample_now = (state_q == ST_SAMPLE) && phase_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_wr_d = prio_wr_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (grant_wr) begin
          state_d   = ST_DRIVE;
          cnt_d     = DRIVE_LD;
          prio_wr_d = 1'b0;
        end else if (grant_rd) begin
          state_d   = ST_SAMPLE;
          cnt_d     = RD_LD;
          prio_wr_d = 1'b1;
        end
      end
      ST_DRIVE, ST_SAMPLE: begin
        if (phase_done) begin
          state_d = ST_TURN;
          cnt_d   = TURN_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_TURN: begin
        if (phase_done) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // data_out recirculates the value captured at the grant edge, so later
  // wr_data changes never reach the pin.
  always_comb begin
    dir_d      = (state_d == ST_DRIVE);
    data_out_d = '0;
    if (grant_wr) begin
      data_out_d = wr_data;
    end else if (state_d == ST_DRIVE) begin
      data_out_d = data_out;
    end
    wr_ack_d   = grant_wr;
    rd_ack_d   = grant_rd;
    rd_valid_d = sample_now;
    rd_data_d  = sample_now ? data_in : rd_data;
    busy_d     = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_bidir_pin_ctrl.sv
// Directed bench for bidir_pin_ctrl; a negedge monitor pops expected grants
// and read results from scoreboard queues filled by the stimulus process.
module tb_bidir_pin_ctrl;

  localparam int W    = 4;
  localparam int DRV  = 2;
  localparam int RDL  = 2;
  localparam int TRN  = 2;

  typedef struct packed {
    logic         is_rd;
    logic [W-1:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         wr_req;
  logic [W-1:0] wr_data;
  logic         wr_ack;
  logic         rd_req;
  logic         rd_ack;
  logic [W-1:0] rd_data;
  logic         rd_valid;
  logic         dir;
  logic [W-1:0] data_out;
  logic [W-1:0] data_in;
  logic         busy;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  exp_t         grant_q[$];
  logic [W-1:0] rdv_q[$];

  bidir_pin_ctrl #(.WIDTH(W), .DRIVE_CYC(DRV), .RD_LAT(RDL), .TURN(TRN)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .dir(dir), .data_out(data_out), .data_in(data_in), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  // Monitor: checks every grant and every rd_valid against the scoreboard.
  int last_ack_cyc = -1;
  int last_dir_cyc = -1;
  int last_lat     = 0;
  always @(negedge clk) begin
    exp_t         e;
    logic [W-1:0] rv;
    if (!rst_n) begin
      last_ack_cyc = -1;
      last_dir_cyc = -1;
    end else begin
      if (!dir) chk("data_out_released", 32'(data_out), 0);
      else      chk("busy_while_driving", 32'(busy), 1);
      chk("single_grant", 32'(wr_ack && rd_ack), 0);
      if (dir) last_dir_cyc = cyc;
      if (wr_ack || rd_ack) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", 32'({wr_ack, rd_ack}), 0);
        end else begin
          e = grant_q.pop_front();
          chk("grant_kind_rd", 32'(rd_ack), 32'(e.is_rd));
          if (!e.is_rd) chk("wr_captured", 32'(data_out), 32'(e.data));
          if (last_ack_cyc >= 0)
            chk("grant_spacing", 32'((cyc - last_ack_cyc) >= (last_lat + TRN + 1)), 1);
          if (rd_ack && last_dir_cyc >= 0)
            chk("turnaround_before_read", 32'((cyc - last_dir_cyc) >= (TRN + 1)), 1);
        end
        last_ack_cyc = cyc;
        last_lat     = rd_ack ? RDL : DRV;
      end
      if (rd_valid) begin
        if (rdv_q.size() == 0) begin
          chk("unexpected_rd_valid", 32'(rd_valid), 0);
        end else begin
          rv = rdv_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(rv));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_c[3];
    int k;
    int wr_seen;
    int c0;
    bit found;

    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0; data_in = '0;
    repeat (3) tick();
    chk("rst_dir", 32'(dir), 0);
    chk("rst_data_out", 32'(data_out), 0);
    chk("rst_acks", 32'({wr_ack, rd_ack, rd_valid}), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick();

    // single write
    wr_data = 4'h1; wr_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b0, data: 4'h1});
    tick();
    chk("w1_ack", 32'(wr_ack), 1);
    chk("w1_dir", 32'(dir), 1);
    chk("w1_data", 32'(data_out), 1);
    chk("w1_busy", 32'(busy), 1);
    wr_req = 1'b0;
    tick();
    chk("w2_ack", 32'(wr_ack), 0);
    chk("w2_dir", 32'(dir), 1);
    chk("w2_data", 32'(data_out), 1);
    tick();
    chk("w3_dir", 32'(dir), 0);
    chk("w3_busy", 32'(busy), 1);
    tick();
    chk("w4_dir", 32'(dir), 0);
    chk("w4_busy", 32'(busy), 1);
    tick();
    chk("w5_busy", 32'(busy), 0);

    // single read
    data_in = 4'h1; rd_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b1, data: 4'h0});
    rdv_q.push_back(4'h1);
    tick();
    chk("r1_ack", 32'(rd_ack), 1);
    chk("r1_dir", 32'(dir), 0);
    rd_req = 1'b0;
    tick();
    chk("r2_ack", 32'(rd_ack), 0);
    chk("r2_valid", 32'(rd_valid), 0);
    tick();
    chk("r3_valid", 32'(rd_valid), 1);
    chk("r3_data", 32'(rd_data), 1);
    chk("r3_dir", 32'(dir), 0);
    tick();
    chk("r4_valid", 32'(rd_valid), 0);
    chk("r4_hold", 32'(rd_data), 1);
    chk("r4_busy", 32'(busy), 1);
    tick();
    chk("r5_busy", 32'(busy), 0);

    // contention: write, read, write with exact 5-cycle grant spacing
    wr_data = 4'hA; data_in = 4'h5; wr_req = 1'b1; rd_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b0, data: 4'hA});
    grant_q.push_back('{is_rd: 1'b1, data: 4'h0});
    grant_q.push_back('{is_rd: 1'b0, data: 4'h3});
    rdv_q.push_back(4'h5);
    ack_c = '{0, 0, 0}; k = 0; wr_seen = 0;
    for (int i = 0; i < 40 && k < 3; i++) begin
      tick();
      if (wr_ack) begin
        ack_c[k] = cyc; k++; wr_seen++;
        if (wr_seen == 1) wr_data = 4'h3;
        else wr_req = 1'b0;
      end
      if (rd_ack) begin
        ack_c[k] = cyc; k++;
        rd_req = 1'b0;
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    chk("cont_grants", 32'(k), 3);
    chk("cont_gap1", 32'(ack_c[1] - ack_c[0]), 5);
    chk("cont_gap2", 32'(ack_c[2] - ack_c[1]), 5);
    wait_idle();

    // write immediately followed by read
    wr_data = 4'h6; data_in = 4'h9; wr_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b0, data: 4'h6});
    grant_q.push_back('{is_rd: 1'b1, data: 4'h0});
    rdv_q.push_back(4'h9);
    tick();
    chk("wr_rd_wack", 32'(wr_ack), 1);
    c0 = cyc; wr_req = 1'b0; rd_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (rd_ack) found = 1'b1;
    end
    rd_req = 1'b0;
    chk("wr_rd_found", 32'(found), 1);
    chk("wr_rd_gap", 32'(cyc - c0), 5);
    wait_idle();

    // reset in second DRIVE cycle, then post-reset priority is write
    wr_data = 4'h7; wr_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b0, data: 4'h7});
    tick();
    chk("abort_wack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    tick();
    chk("abort_dir_before", 32'(dir), 1);
    rst_n = 1'b0; rd_req = 1'b1;
    tick();
    chk("abort_dir", 32'(dir), 0);
    chk("abort_data", 32'(data_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_rd_data", 32'(rd_data), 0);
    wr_req = 1'b1; wr_data = 4'h2; data_in = 4'hC;
    tick();
    chk("abort_no_grant", 32'({wr_ack, rd_ack, busy}), 0);
    rst_n = 1'b1;
    grant_q.push_back('{is_rd: 1'b0, data: 4'h2});
    grant_q.push_back('{is_rd: 1'b1, data: 4'h0});
    rdv_q.push_back(4'hC);
    tick();
    chk("post_rst_wack", 32'(wr_ack), 1);
    chk("post_rst_rack", 32'(rd_ack), 0);
    wr_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (rd_ack) found = 1'b1;
    end
    rd_req = 1'b0;
    chk("post_rst_read", 32'(found), 1);
    wait_idle();

    // wr_data changed during DRIVE is ignored
    wr_data = 4'hB; wr_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b0, data: 4'hB});
    tick();
    chk("hold_d1", 32'(data_out), 32'(4'hB));
    wr_data = 4'h4; wr_req = 1'b0;
    tick();
    chk("hold_d2", 32'(data_out), 32'(4'hB));
    chk("hold_dir", 32'(dir), 1);
    wait_idle();

    // request raised and dropped during TURN is never granted
    data_in = 4'h3; rd_req = 1'b1;
    grant_q.push_back('{is_rd: 1'b1, data: 4'h0});
    rdv_q.push_back(4'h3);
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    wr_req = 1'b1; wr_data = 4'hF;
    tick();
    wr_req = 1'b0;
    repeat (6) tick();
    chk("dropped_req_idle", 32'({wr_ack, busy}), 0);

    chk("grant_q_empty", 32'(grant_q.size()), 0);
    chk("rdv_q_empty", 32'(rdv_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bidir_pin_ctrl.md
BIDIR_PIN_CTRL -- requirements
Module: bidir_pin_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 1: bit width of the pin and of all data ports.
REQ-002 SHALL have parameter DRIVE_CYC, default 2: number of cycles the pin is driven per write (legal range 1..15).
REQ-003 SHALL have parameter RD_LAT, default 2: number of cycles from read grant to pin sample (legal range 1..15).
REQ-004 SHALL have parameter TURN, default 2: number of bus-release turnaround cycles after every transaction (legal range 1..15).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port wr_req, input, 1 bit: write request; held until wr_ack is seen.
REQ-008 SHALL have port wr_data, input, WIDTH bits: write value; valid while wr_req is high.
REQ-009 SHALL have port wr_ack, output, 1 bit: one-cycle write-grant pulse.
REQ-010 SHALL have port rd_req, input, 1 bit: read request; held until rd_ack is seen.
REQ-011 SHALL have port rd_ack, output, 1 bit: one-cycle read-grant pulse.
REQ-012 SHALL have port rd_data, output, WIDTH bits: last sampled pin value.
REQ-013 SHALL have port rd_valid, output, 1 bit: one-cycle pulse marking new rd_data.
REQ-014 SHALL have port dir, output, 1 bit: pin direction to bidir_pin; 1 = drive, 0 = release.
REQ-015 SHALL have port data_out, output, WIDTH bits: value driven onto the pin.
REQ-016 SHALL have port data_in, input, WIDTH bits: pin value returned from bidir_pin.
REQ-017 SHALL have port busy, output, 1 bit: high whenever the FSM state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, DRIVE, SAMPLE and TURN.
REQ-019 SHALL register all outputs, with no combinational path from any input to any output.
REQ-020 SHALL sample requests only in IDLE; a request seen at the clock edge ending an IDLE cycle grants the transfer at that edge.
REQ-021 SHALL arbitrate simultaneous wr_req and rd_req round-robin: the type not granted last wins; after reset, write wins.
REQ-022 SHALL move a write grant IDLE->DRIVE, capture wr_data at the grant edge, and hold wr_ack=1 for the first DRIVE cycle only.
REQ-023 SHALL stay in DRIVE for DRIVE_CYC cycles with dir=1 and data_out equal to the captured value, then go to TURN.
REQ-024 SHALL move a read grant IDLE->SAMPLE and hold rd_ack=1 for the first SAMPLE cycle only.
REQ-025 SHALL keep dir=0 in SAMPLE and sample data_in at the edge ending the RD_LAT-th SAMPLE cycle, then go to TURN.
REQ-026 SHALL present the sampled value on rd_data with rd_valid=1 during the first TURN cycle, and hold rd_data until the next sample.
REQ-027 SHALL keep dir=0 in TURN for TURN cycles, then go to IDLE; requests present during TURN wait for IDLE.
REQ-028 SHALL therefore give every transaction a total latency of DRIVE_CYC+TURN (write) or RD_LAT+TURN (read) cycles from grant edge to IDLE, with no back-to-back grant that skips TURN.
REQ-029 SHALL drive data_out to all-zero whenever dir=0.
REQ-030 SHALL never assert dir in IDLE, SAMPLE or TURN.
REQ-031 SHALL use 4-bit phase counters that reload on each state entry, never wrap, and make each state last exactly its parameter count.
REQ-032 SHALL ignore wr_data changes after the grant edge.
REQ-033 SHALL ignore a request deasserted before its grant, with no ack issued.

Reset
REQ-034 SHALL, on rst_n=0 at a clock edge, set state IDLE, dir=0, data_out=0, wr_ack=0, rd_ack=0, rd_valid=0, rd_data=0, busy=0, counters=0 and round-robin priority=write.
REQ-035 SHALL let reset asserted mid-DRIVE release the pin (dir=0) at that same edge and abort the transfer with no further ack or rd_valid.
REQ-036 SHALL let the first grant after reset occur no earlier than the edge ending the first cycle with rst_n=1.

Verification
REQ-037 SHALL check single write: wr_req=1, wr_data=1 in IDLE -> wr_ack pulse 1 cycle; dir=1, data_out=1 for 2 cycles; dir=0 for 2 cycles; busy low in cycle 5.
REQ-038 SHALL check single read: rd_req=1, data_in=1 -> rd_ack next cycle; dir=0 throughout; rd_valid=1, rd_data=1 in cycle 3; IDLE in cycle 5.
REQ-039 SHALL check contention: wr_req and rd_req both held -> grants alternate write, read, write; every pair of grants separated by 2 TURN cycles with dir=0.
REQ-040 SHALL check write immediately followed by read: dir falls to 0 at least TURN=2 cycles before the read grant edge.
REQ-041 SHALL check reset in second DRIVE cycle: rst_n=0 -> next cycle dir=0, data_out=0, busy=0; no rd_valid pulse.
REQ-042 SHALL check data hold: change wr_data in DRIVE cycle 1 -> data_out keeps the captured value for both DRIVE cycles.
